// File: rtl/lsu_burst.sv
// Burst load-store unit: one LDR/STR moves BURST_LEN consecutive words at rs.
// Optional per-beat response timeout is compiled in with LSU_BURST_TIMEOUT_EN.
module lsu_burst #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int BURST_LEN      = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [2:0]                     core_state,
  input  logic                           decoded_mem_read_enable,
  input  logic                           decoded_mem_write_enable,
  input  logic [ADDR_BITS-1:0]           rs,
  input  logic [BURST_LEN*DATA_BITS-1:0] rt,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_address,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic                           mem_write_valid,
  output logic [ADDR_BITS-1:0]           mem_write_address,
  output logic [DATA_BITS-1:0]           mem_write_data,
  input  logic                           mem_write_ready,
  output logic [1:0]                     lsu_state,
  output logic [BURST_LEN*DATA_BITS-1:0] lsu_out,
  output logic                           lsu_error
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUESTING = 2'd1,
    WAITING    = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e                         state_q, state_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic                           read_valid_q, read_valid_d;
  logic                           write_valid_q, write_valid_d;
  logic [ADDR_BITS-1:0]           read_addr_q, read_addr_d;
  logic [ADDR_BITS-1:0]           write_addr_q, write_addr_d;
  logic [DATA_BITS-1:0]           write_data_q, write_data_d;
  logic [BURST_LEN*DATA_BITS-1:0] lsu_out_q, lsu_out_d;
  logic                           error_q, error_d;

  logic [ADDR_BITS-1:0] beat_addr;
  logic [DATA_BITS-1:0] beat_wdata;
  logic                 beat_ack;
  logic                 tmo_hit;

  // Address arithmetic is modulo 2^ADDR_BITS, so a burst may wrap past the top.
  assign beat_addr  = rs + ADDR_BITS'(beat_q);
  assign beat_wdata = rt[beat_q*DATA_BITS +: DATA_BITS];
  assign beat_ack   = (read_valid_q && mem_read_ready) || (write_valid_q && mem_write_ready);

`ifdef LSU_BURST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counter is zero in every state but WAITING, so it restarts on each entry.
  assign tmo_d   = (state_q == WAITING) ? tmo_q + 1'b1 : '0;
  assign tmo_hit = (state_q == WAITING) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (enable) begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    beat_d        = beat_q;
    read_valid_d  = read_valid_q;
    write_valid_d = write_valid_q;
    read_addr_d   = read_addr_q;
    write_addr_d  = write_addr_q;
    write_data_d  = write_data_q;
    lsu_out_d     = lsu_out_q;
    error_d       = error_q;

    unique case (state_q)
      IDLE: begin
        if (core_state == CORE_REQUEST) begin
          if (decoded_mem_read_enable && decoded_mem_write_enable) begin
            state_d = DONE;
            error_d = 1'b1;
          end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
            state_d = REQUESTING;
            beat_d  = '0;
            error_d = 1'b0;
            if (decoded_mem_read_enable) lsu_out_d = '0;
          end
        end
      end

      REQUESTING: begin
        state_d = WAITING;
        if (decoded_mem_read_enable) begin
          read_valid_d = 1'b1;
          read_addr_d  = beat_addr;
        end else if (decoded_mem_write_enable) begin
          write_valid_d = 1'b1;
          write_addr_d  = beat_addr;
          write_data_d  = beat_wdata;
        end else begin
          // Op vanished mid-burst: retire with an error rather than wait forever.
          state_d = DONE;
          error_d = 1'b1;
        end
      end

      WAITING: begin
        if (beat_ack) begin
          read_valid_d  = 1'b0;
          write_valid_d = 1'b0;
          if (read_valid_q) lsu_out_d[beat_q*DATA_BITS +: DATA_BITS] = mem_read_data;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = REQUESTING;
          end
        end else if (tmo_hit) begin
          read_valid_d  = 1'b0;
          write_valid_d = 1'b0;
          error_d       = 1'b1;
          state_d       = DONE;
        end
      end

      DONE: begin
        if (core_state == CORE_UPDATE) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the load buffer is ordinary flops read by the core, so it is cleared on reset too.
      state_q       <= IDLE;
      beat_q        <= '0;
      read_valid_q  <= 1'b0;
      write_valid_q <= 1'b0;
      read_addr_q   <= '0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      lsu_out_q     <= '0;
      error_q       <= 1'b0;
    end else if (enable) begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q       <= state_d;
      beat_q        <= beat_d;
      read_valid_q  <= read_valid_d;
      write_valid_q <= write_valid_d;
      read_addr_q   <= read_addr_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      lsu_out_q     <= lsu_out_d;
      error_q       <= error_d;
    end
  end

  assign mem_read_valid    = read_valid_q;
  assign mem_read_address  = read_addr_q;
  assign mem_write_valid   = write_valid_q;
  assign mem_write_address = write_addr_q;
  assign mem_write_data    = write_data_q;
  assign lsu_state         = state_q;
  assign lsu_out           = lsu_out_q;
  assign lsu_error         = error_q;

endmodule

// File: tb/tb_lsu_burst.sv
// Directed bench for lsu_burst: a BURST_LEN=4 instance behind a delay-programmable
// memory responder, plus a BURST_LEN=1 instance handshaken by hand.
module tb_lsu_burst;

  localparam logic [2:0] CS_REQUEST = 3'b011;
  localparam logic [2:0] CS_EXECUTE = 3'b100;
  localparam logic [2:0] CS_UPDATE  = 3'b110;
  localparam logic [2:0] CS_OTHER   = 3'b000;

  logic clk = 1'b0;
  logic reset, enable;
  always #5 clk = ~clk;

  // BURST_LEN=4 instance
  logic [2:0]  core_state;
  logic        rd_en, wr_en;
  logic [7:0]  rs;
  logic [31:0] rt;
  logic        read_valid, write_valid, read_ready, write_ready, lsu_error;
  logic [7:0]  read_addr, write_addr, write_data, read_data;
  logic [1:0]  lsu_state;
  logic [31:0] lsu_out;

  // BURST_LEN=1 instance
  logic [2:0] cs1;
  logic       rd1, wr1, rready1, wready1, rvalid1, wvalid1, err1;
  logic [7:0] rs1, rt1, rdata1, raddr1, waddr1, wdata1, out1;
  logic [1:0] state1;

  lsu_burst #(.ADDR_BITS(8), .DATA_BITS(8), .BURST_LEN(4), .TIMEOUT_CYCLES(8)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(read_valid), .mem_read_address(read_addr),
    .mem_read_ready(read_ready), .mem_read_data(read_data),
    .mem_write_valid(write_valid), .mem_write_address(write_addr),
    .mem_write_data(write_data), .mem_write_ready(write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
  );

  lsu_burst #(.ADDR_BITS(8), .DATA_BITS(8), .BURST_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .core_state(cs1),
    .decoded_mem_read_enable(rd1), .decoded_mem_write_enable(wr1),
    .rs(rs1), .rt(rt1),
    .mem_read_valid(rvalid1), .mem_read_address(raddr1),
    .mem_read_ready(rready1), .mem_read_data(rdata1),
    .mem_write_valid(wvalid1), .mem_write_address(waddr1),
    .mem_write_data(wdata1), .mem_write_ready(wready1),
    .lsu_state(state1), .lsu_out(out1), .lsu_error(err1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: raises ready after valid has been seen high resp_delay times.
  logic [7:0] mem_img [256];
  int         resp_delay = 1;
  int         vcnt = 0;
  logic       acked = 1'b0;
  logic       rv_seen = 1'b0, wv_seen = 1'b0, both_seen = 1'b0, unstable = 1'b0;
  logic [7:0] cur_addr, hold_addr, hold_data;
  logic [7:0] log_addr [16];
  logic [7:0] log_data [16];
  logic       log_wr   [16];
  int         log_n = 0;

  initial begin
    read_ready  = 1'b0;
    write_ready = 1'b0;
    read_data   = '0;
    forever begin
      @(negedge clk);
      if (read_valid) rv_seen = 1'b1;
      if (write_valid) wv_seen = 1'b1;
      if (read_valid && write_valid) both_seen = 1'b1;
      if (read_valid || write_valid) begin
        cur_addr = read_valid ? read_addr : write_addr;
        if (vcnt == 0) begin
          hold_addr = cur_addr;
          hold_data = write_data;
        end else if (cur_addr != hold_addr || (write_valid && write_data != hold_data)) begin
          unstable = 1'b1;
        end
        vcnt++;
        if (vcnt >= resp_delay) begin
          if (!acked && log_n < 16) begin
            log_addr[log_n] = cur_addr;
            log_data[log_n] = read_valid ? mem_img[read_addr] : write_data;
            log_wr[log_n]   = write_valid;
            log_n++;
            acked = 1'b1;
          end
          if (read_valid) begin
            read_ready = 1'b1;
            read_data  = mem_img[read_addr];
          end else begin
            write_ready = 1'b1;
          end
        end
      end else begin
        read_ready  = 1'b0;
        write_ready = 1'b0;
        read_data   = '0;
        vcnt        = 0;
        acked       = 1'b0;
      end
    end
  end

  task automatic clear_flags();
    log_n = 0; rv_seen = 1'b0; wv_seen = 1'b0; both_seen = 1'b0; unstable = 1'b0;
  endtask

  // Present REQUEST for one edge, then move the core on to EXECUTE.
  task automatic issue(input logic rd, input logic wr, input logic [7:0] base, input logic [31:0] data);
    core_state = CS_REQUEST; rd_en = rd; wr_en = wr; rs = base; rt = data;
    @(negedge clk);
    core_state = CS_EXECUTE;
  endtask

  task automatic wait_state(input logic [1:0] s, output int cycles);
    cycles = 0;
    while (lsu_state != s && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic retire(input string tag);
    core_state = CS_UPDATE;
    @(negedge clk);
    check(tag, lsu_state, 2'd0);
    core_state = CS_OTHER; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  logic [7:0] st_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] st_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; enable = 1'b1;
    core_state = CS_OTHER; rd_en = 1'b0; wr_en = 1'b0; rs = '0; rt = '0;
    cs1 = CS_OTHER; rd1 = 1'b0; wr1 = 1'b0; rs1 = '0; rt1 = '0;
    rready1 = 1'b0; wready1 = 1'b0; rdata1 = '0;
    for (int i = 0; i < 256; i++) mem_img[i] = 8'h00;
    mem_img[8'h30] = 8'hC1; mem_img[8'h31] = 8'hC2; mem_img[8'h32] = 8'hC3; mem_img[8'h33] = 8'hC4;
    mem_img[8'h40] = 8'h9A; mem_img[8'h41] = 8'hBC; mem_img[8'h42] = 8'hDE; mem_img[8'h43] = 8'hF0;
    repeat (3) @(negedge clk);
    check("rst_state", lsu_state, 2'd0);
    check("rst_valids", {read_valid, write_valid}, 2'b00);
    check("rst_out", lsu_out, 32'h0);
    check("rst_err", lsu_error, 1'b0);
    check("rst_state1", state1, 2'd0);
    reset = 1'b0;

    // BURST_LEN=1 load, handshaken by hand
    cs1 = CS_REQUEST; rd1 = 1'b1; rs1 = 8'h10;
    @(negedge clk);
    check("a_requesting", state1, 2'd1);
    check("a_valid_early", rvalid1, 1'b0);
    cs1 = CS_EXECUTE;
    @(negedge clk);
    check("a_waiting", state1, 2'd2);
    check("a_valid", rvalid1, 1'b1);
    check("a_addr", raddr1, 8'h10);
    rready1 = 1'b1; rdata1 = 8'hA5;
    @(negedge clk);
    rready1 = 1'b0; rdata1 = 8'h00;
    check("a_done", state1, 2'd3);
    check("a_valid_drop", rvalid1, 1'b0);
    check("a_out", out1, 8'hA5);
    repeat (3) @(negedge clk);
    check("a_hold_done", state1, 2'd3);
    check("a_hold_out", out1, 8'hA5);
    cs1 = CS_UPDATE;
    @(negedge clk);
    check("a_idle", state1, 2'd0);
    cs1 = CS_OTHER; rd1 = 1'b0;

    // BURST_LEN=4 store wrapping past 0xFF, ready one cycle after valid
    clear_flags(); resp_delay = 1;
    issue(1'b0, 1'b1, 8'hFE, 32'h44332211);
    wait_state(2'd3, cyc);
    check("b_latency", 32'(cyc + 1), 32'd9);
    check("b_beats", 32'(log_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_addr%0d", i), log_addr[i], st_addr[i]);
      check($sformatf("b_data%0d", i), log_data[i], st_data[i]);
      check($sformatf("b_wr%0d", i), log_wr[i], 1'b1);
    end
    check("b_no_read", rv_seen, 1'b0);
    check("b_err", lsu_error, 1'b0);
    retire("b_idle");

    // BURST_LEN=4 load, ready 3 cycles after each valid
    clear_flags(); resp_delay = 3;
    issue(1'b1, 1'b0, 8'h30, 32'h0);
    wait_state(2'd3, cyc);
    check("c_latency", 32'(cyc + 1), 32'd17);
    check("c_out", lsu_out, 32'hC4C3C2C1);
    check("c_err", lsu_error, 1'b0);
    check("c_stable", unstable, 1'b0);
    check("c_no_write", wv_seen, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("c_addr%0d", i), log_addr[i], 8'h30 + 8'(i));
    retire("c_idle");

    // Second load must start from a cleared buffer
    clear_flags(); resp_delay = 1;
    issue(1'b1, 1'b0, 8'h40, 32'h0);
    check("c2_cleared", lsu_out, 32'h0);
    wait_state(2'd3, cyc);
    check("c2_out", lsu_out, 32'hF0DEBC9A);
    retire("c2_idle");

    // Both decoded enables: immediate error, no access
    clear_flags();
    issue(1'b1, 1'b1, 8'h20, 32'h0);
    check("d_done", lsu_state, 2'd3);
    check("d_err", lsu_error, 1'b1);
    repeat (2) @(negedge clk);
    check("d_no_valid", {rv_seen, wv_seen}, 2'b00);
    retire("d_idle");

    // Freeze mid-WAITING, then reset mid-burst
    clear_flags(); resp_delay = 1000;
    issue(1'b1, 1'b0, 8'h50, 32'h0);
    @(negedge clk);
    check("e_waiting", lsu_state, 2'd2);
    enable = 1'b0;
    core_state = CS_UPDATE;
    repeat (5) @(negedge clk);
    check("e_frz_state", lsu_state, 2'd2);
    check("e_frz_valid", read_valid, 1'b1);
    check("e_frz_addr", read_addr, 8'h50);
    enable = 1'b1; core_state = CS_EXECUTE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; core_state = CS_OTHER;
    check("e_rst_state", lsu_state, 2'd0);
    check("e_rst_valid", read_valid, 1'b0);
    check("e_rst_addr", read_addr, 8'h00);
    check("e_rst_err", lsu_error, 1'b0);
    rv_seen = 1'b0;
    repeat (5) @(negedge clk);
    check("e_no_beats", {rv_seen, 8'(log_n)}, 9'h000);
    rd_en = 1'b0;

`ifdef LSU_BURST_TIMEOUT_EN
    // Timeout after 8 WAITING cycles
    clear_flags(); resp_delay = 1000;
    issue(1'b1, 1'b0, 8'h60, 32'h0);
    wait_state(2'd3, cyc);
    check("f_latency", 32'(cyc + 1), 32'd10);
    check("f_err", lsu_error, 1'b1);
    check("f_valid", read_valid, 1'b0);
    retire("f_idle");
`endif

    check("never_both_valid", both_seen, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_burst.md
Name: lsu_burst

Overview:
- Parametrised successor to the per-thread load-store unit; one instance per thread inside a compute core.
- Executes LDR/STR as a burst of BURST_LEN consecutive words starting at base address rs, with configurable address/data widths.
- Runs the same IDLE/REQUESTING/WAITING/DONE handshake against data memory and is sequenced by the core state (REQUEST starts, UPDATE retires).
- Adds beat counting, illegal-op detection and an optional response timeout.

Parameters:
ADDR_BITS, 8, width of memory address and rs
DATA_BITS, 8, width of one memory word
BURST_LEN, 1, words per LDR/STR (1..16)
TIMEOUT_CYCLES, 64, max WAITING cycles per beat (used only with LSU_BURST_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  thread active in current block; low = state and outputs frozen
core_state  in  3  core stage; REQUEST=3'b011, UPDATE=3'b110
decoded_mem_read_enable  in  1  LDR decoded
decoded_mem_write_enable  in  1  STR decoded
rs  in  ADDR_BITS  burst base address
rt  in  BURST_LEN*DATA_BITS  store data; word i in bits [i*DATA_BITS +: DATA_BITS]
mem_read_valid  out  1  read request
mem_read_address  out  ADDR_BITS  read address
mem_read_ready  in  1  read data valid / ack
mem_read_data  in  DATA_BITS  read data
mem_write_valid  out  1  write request
mem_write_address  out  ADDR_BITS  write address
mem_write_data  out  DATA_BITS  write data
mem_write_ready  in  1  write ack
lsu_state  out  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3
lsu_out  out  BURST_LEN*DATA_BITS  loaded words, same packing as rt
lsu_error  out  1  sticky per-instruction error; valid in DONE

Behaviour:
- Reset: lsu_state=IDLE; all valids 0; addresses, write data, lsu_out, lsu_error, beat counter 0. Reset mid-burst drops valid on the next edge; no further beats are issued.
- enable=0: no state, counter or output changes. An asserted valid stays asserted.
- IDLE:
  - Holds unless core_state==REQUEST and exactly one decoded enable is set; then -> REQUESTING, beat=0, lsu_error=0.
  - For a load, lsu_out is also cleared to 0.
  - Both enables set in REQUEST: -> DONE with lsu_error=1; no memory access.
  - Neither enable set: stay IDLE.
- REQUESTING: assert the op's valid; address = rs + beat, modulo 2^ADDR_BITS (wraps). For a store, write data = rt word[beat]. Then -> WAITING.
- WAITING: hold valid/address/data until ready is sampled high. On ready:
  - Drop valid.
  - For a load, capture mem_read_data into lsu_out word[beat].
  - If beat==BURST_LEN-1 -> DONE; else beat+1 -> REQUESTING.
  - Ready while valid is low is ignored.
- DONE: hold lsu_out/lsu_error until core_state==UPDATE, then -> IDLE.
- rs, rt and the decoded enables are sampled every cycle of the op; the core holds them stable from REQUEST until UPDATE.
- Latency: REQUEST seen at edge N -> REQUESTING at N+1, valid high after N+2. Minimum 2 cycles per beat, so DONE no earlier than N+1+2*BURST_LEN.
- Read and write valid are never high simultaneously.

Optional Feature:
- LSU_BURST_TIMEOUT_EN defined:
  - A per-beat counter resets on entry to WAITING.
  - If ready is not seen after TIMEOUT_CYCLES cycles in WAITING: drop valid, set lsu_error=1, -> DONE. Remaining beats are skipped; already-loaded words are kept.
- Undefined: no counter logic; WAITING waits indefinitely.

Test Plan:
- BURST_LEN=1, LDR, rs=0x10, memory returns 0xA5 one cycle after valid -> read_address=0x10; lsu_out=0xA5; DONE; returns to IDLE only when core_state=UPDATE.
- BURST_LEN=4, STR, rs=0xFE, rt=0x44332211, ready each cycle -> write beats (0xFE,0x11), (0xFF,0x22), (0x00,0x33), (0x01,0x44); address wraps; read_valid stays 0.
- BURST_LEN=4, LDR with ready delayed 3 cycles per beat -> address/valid stable while waiting; lsu_out assembled in order; lsu_error=0.
- Both decoded enables high in REQUEST -> DONE next cycle, lsu_error=1, no valid asserted.
- enable dropped for 5 cycles mid-WAITING, then reset asserted mid-burst -> frozen during enable=0; after reset all outputs 0, IDLE, no further beats.
- LSU_BURST_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready never asserted -> valid drops after 8 WAITING cycles; DONE with lsu_error=1.
